regfile_multiport: RTL and testbench

- Parametrised successor to the core's register file.
- Adds:
  - configurable data width, register count and read-port count;
  - deterministic write-collision priority;
  - optional same-cycle write-to-read bypass for the pipeline;
  - hardware clear sequencer, started by reset or by a soft request, replacing file-loaded initialisation.
- Sits between decode (read) and writeback (write) stages of the pipelined processor.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_read_port.sv | 45 ++++
 rtl/regfile_multiport.sv | 130 +++++++++++++
 tb/tb_regfile_multiport.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file.
//   - default geometry constants (data width, register count, read ports)
//   - state encoding for the clear sequencer
//   - helper that returns the LSB offset of a lane inside a packed bus
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 64;
  localparam int DEF_NUM_RD = 3;

  // ST_CLEAR: sequencer zeroes one register per cycle, file not ready.
  // ST_RUN:   normal operation, reads valid and writes accepted.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  // Bit offset of lane 'lane' in a bus made of 'width'-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read lane of the register file.
// Ports:
//   ready     in  file is in RUN; when low the lane reads zero
//   rd_addr   in  register index for this lane
//   arr_data  in  storage array value at rd_addr (pre-edge contents)
//   wr1_*     in  write port 1 (enable/index/data), used for bypass
//   wr2_*     in  write port 2 (enable/index/data), used for bypass
//   rd_data   out data returned to the decode stage
module regfile_read_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              ready,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              wr1_en,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  input  logic              wr2_en,
  input  logic [ADDR_W-1:0] wr2_addr,
  input  logic [DATA_W-1:0] wr2_data,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = arr_data;
    // wr2 is checked first so the bypass agrees with the port that wins a
    // same-index write collision in the array.
    if (BYPASS != 0) begin
      if (wr2_en && (rd_addr == wr2_addr)) begin
        rd_data = wr2_data;
      end else if (wr1_en && (rd_addr == wr1_addr)) begin
        rd_data = wr1_data;
      end
    end
    // Not-ready gating and the hardwired zero register override everything,
    // including the bypass path.
    if (!ready || ((ZERO_R0 != 0) && (rd_addr == '0))) begin
      rd_data = '0;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multiport register file with two write ports, NUM_RD
// combinational read ports, write-collision flag, optional write-to-read
// bypass and a hardware clear sequencer.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   clear_req      start a soft clear; only acted on while ready=1
//   rd_addr        packed read indices, lane k at [k*ADDR_W +: ADDR_W]
//   rd_data        packed read data,    lane k at [k*DATA_W +: DATA_W]
//   wr1_*, wr2_*   write ports (enable/index/data); wr2 wins on same index
//   ready          file accepts writes and reads are valid
//   wr_collision   one-cycle pulse the cycle after both ports hit one index
//
// Interface contract: there is no per-transfer handshake. While ready=1
// every enabled write commits on the next rising edge and every read lane
// is valid in the same cycle; while ready=0 writes are dropped and reads
// return zero. ready is registered and follows the sequencer state.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear_req,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr2_addr,
  input  logic [DATA_W-1:0]        wr2_data,
  input  logic                     wr2_en,
  output logic                     ready,
  output logic                     wr_collision
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              coll_q, coll_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              w1_ok, w2_ok;

  always_comb begin
    mem_d   = mem_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    coll_d  = 1'b0;
    // A write to index 0 with ZERO_R0 is dropped before it can reach the
    // array or the collision detector.
    w1_ok = wr1_en && !((ZERO_R0 != 0) && (wr1_addr == '0));
    w2_ok = wr2_en && !((ZERO_R0 != 0) && (wr2_addr == '0));
    case (state_q)
      ST_CLEAR: begin
        mem_d[cnt_q] = '0;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // wr2 is applied last so it overwrites wr1 on a shared index.
        if (w1_ok) mem_d[wr1_addr] = wr1_data;
        if (w2_ok) mem_d[wr2_addr] = wr2_data;
        coll_d = w1_ok && w2_ok && (wr1_addr == wr2_addr);
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      coll_q  <= coll_d;
    end
  end

  // Storage is deliberately not reset; the clear sequencer zeroes it.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign ready        = ready_q;
  assign wr_collision = coll_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr_k;
    assign addr_k = rd_addr[lane_lsb(k, ADDR_W) +: ADDR_W];

    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS),
      .ZERO_R0(ZERO_R0)
    ) u_rd (
      .ready   (ready_q),
      .rd_addr (addr_k),
      .arr_data(mem_q[addr_k]),
      .wr1_en  (wr1_en),
      .wr1_addr(wr1_addr),
      .wr1_data(wr1_data),
      .wr2_en  (wr2_en),
      .wr2_addr(wr2_addr),
      .wr2_data(wr2_data),
      .rd_data (rd_data[lane_lsb(k, DATA_W) +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport. Three instances share one stimulus stream:
//   inst0: BYPASS=1 ZERO_R0=0, inst1: BYPASS=0 ZERO_R0=0, inst2: BYPASS=1 ZERO_R0=1
// A behavioural model of each file is checked every cycle on the falling
// edge; directed literal checks pin the model at the interesting points.
module tb_regfile_multiport;

  localparam int DW = 16;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int NRD = 3;

  logic clock;
  logic reset;
  logic clear_req;
  logic [NRD*AW-1:0] rd_addr;
  logic [AW-1:0] wr1_addr, wr2_addr;
  logic [DW-1:0] wr1_data, wr2_data;
  logic wr1_en, wr2_en;

  logic [NRD*DW-1:0] rd_data_w [3];
  logic ready_w [3];
  logic coll_w [3];

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUTs ----------------
  regfile_multiport #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .BYPASS(1), .ZERO_R0(0)) dut_a (
    .clock(clock), .reset(reset), .clear_req(clear_req), .rd_addr(rd_addr), .rd_data(rd_data_w[0]),
    .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_en(wr1_en),
    .wr2_addr(wr2_addr), .wr2_data(wr2_data), .wr2_en(wr2_en),
    .ready(ready_w[0]), .wr_collision(coll_w[0]));

  regfile_multiport #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .BYPASS(0), .ZERO_R0(0)) dut_b (
    .clock(clock), .reset(reset), .clear_req(clear_req), .rd_addr(rd_addr), .rd_data(rd_data_w[1]),
    .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_en(wr1_en),
    .wr2_addr(wr2_addr), .wr2_data(wr2_data), .wr2_en(wr2_en),
    .ready(ready_w[1]), .wr_collision(coll_w[1]));

  regfile_multiport #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .BYPASS(1), .ZERO_R0(1)) dut_c (
    .clock(clock), .reset(reset), .clear_req(clear_req), .rd_addr(rd_addr), .rd_data(rd_data_w[2]),
    .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_en(wr1_en),
    .wr2_addr(wr2_addr), .wr2_data(wr2_data), .wr2_en(wr2_en),
    .ready(ready_w[2]), .wr_collision(coll_w[2]));

  function automatic bit byp_of(input int i);
    return i != 1;
  endfunction

  function automatic bit z0_of(input int i);
    return i == 2;
  endfunction

  // ---------------- behavioural model ----------------
  // Observable view: after a clear starts the file is unreadable for DEPTH
  // cycles and then holds all zeros, so the model zeroes it up front.
  logic [DW-1:0] m_mem [3][DEPTH];
  bit m_coll [3];
  int m_left = DEPTH;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_left = DEPTH;
      for (int i = 0; i < 3; i++) begin
        m_coll[i] = 1'b0;
        for (int r = 0; r < DEPTH; r++) m_mem[i][r] = '0;
      end
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      for (int i = 0; i < 3; i++) m_coll[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit w1, w2;
        w1 = wr1_en && !(z0_of(i) && wr1_addr == 0);
        w2 = wr2_en && !(z0_of(i) && wr2_addr == 0);
        m_coll[i] = w1 && w2 && (wr1_addr == wr2_addr);
        if (w1) m_mem[i][wr1_addr] = wr1_data;
        if (w2) m_mem[i][wr2_addr] = wr2_data;
        if (clear_req)
          for (int r = 0; r < DEPTH; r++) m_mem[i][r] = '0;
      end
      if (clear_req) m_left = DEPTH;
    end
  end

  function automatic logic [DW-1:0] exp_lane(input int i, input logic [AW-1:0] a);
    if (m_left != 0) return '0;
    if (z0_of(i) && a == 0) return '0;
    if (byp_of(i) && wr2_en && a == wr2_addr) return wr2_data;
    if (byp_of(i) && wr1_en && a == wr1_addr) return wr1_data;
    return m_mem[i][a];
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model ready inst%0d", i), 64'(ready_w[i]), 64'(m_left == 0));
      check($sformatf("model coll inst%0d", i), 64'(coll_w[i]), 64'(m_coll[i]));
      for (int k = 0; k < NRD; k++)
        check($sformatf("model rd inst%0d lane%0d", i, k),
              64'(rd_data_w[i][k*DW +: DW]), 64'(exp_lane(i, rd_addr[k*AW +: AW])));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    clear_req = 1'b0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    wr2_en = 1'b0; wr2_addr = '0; wr2_data = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  // Counts not-ready cycles until inst0 reports ready (bounded). With poke
  // set, writes are presented during the clear to show they are ignored.
  task automatic count_clear(input string name, input bit poke);
    int cnt;
    cnt = 0;
    if (poke) begin
      wr1_en = 1'b1; wr1_addr = 6'd3; wr1_data = 16'hFFFF;
      wr2_en = 1'b1; wr2_addr = 6'd4; wr2_data = 16'hAAAA;
    end
    while (cnt < 200) begin
      @(negedge clock);
      if (ready_w[0]) break;
      cnt++;
      @(posedge clock);
      #1;
    end
    idle();
    #1;
    check(name, 64'(cnt), 64'd64);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    set_rd(6'd37, 6'd37, 6'd37);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // Reset clear: 64 not-ready cycles, then cleared contents.
    count_clear("reset clear length", 1'b0);
    check("after reset rd a", 64'(rd_data_w[0]), 64'h0);
    check("after reset rd c", 64'(rd_data_w[2]), 64'h0);
    tick();

    // Dual write to distinct indices.
    wr1_en = 1'b1; wr1_addr = 6'd5; wr1_data = 16'h1234;
    wr2_en = 1'b1; wr2_addr = 6'd9; wr2_data = 16'hBEEF;
    tick();
    idle();
    set_rd(6'd5, 6'd9, 6'd5);
    settle();
    check("dual rd a", 64'(rd_data_w[0]), 64'h1234_BEEF_1234);
    check("dual rd b", 64'(rd_data_w[1]), 64'h1234_BEEF_1234);
    check("dual no coll", 64'(coll_w[0]), 64'h0);
    tick();

    // Same-index collision: wr2 wins, one-cycle pulse.
    wr1_en = 1'b1; wr1_addr = 6'd12; wr1_data = 16'h1111;
    wr2_en = 1'b1; wr2_addr = 6'd12; wr2_data = 16'h2222;
    tick();
    idle();
    set_rd(6'd12, 6'd12, 6'd5);
    settle();
    check("coll pulse a", 64'(coll_w[0]), 64'h1);
    check("coll pulse c", 64'(coll_w[2]), 64'h1);
    check("coll rd b", 64'(rd_data_w[1][15:0]), 64'h2222);
    tick();
    settle();
    check("coll drop a", 64'(coll_w[0]), 64'h0);
    tick();

    // Bypass vs. no bypass on a fresh index.
    set_rd(6'd20, 6'd9, 6'd12);
    wr1_en = 1'b1; wr1_addr = 6'd20; wr1_data = 16'hA5A5;
    settle();
    check("bypass pre-edge a", 64'(rd_data_w[0][15:0]), 64'hA5A5);
    check("no bypass pre-edge b", 64'(rd_data_w[1][15:0]), 64'h0000);
    tick();
    idle();
    settle();
    check("no bypass post-edge b", 64'(rd_data_w[1][15:0]), 64'hA5A5);
    tick();

    // Compact directed table of mixed writes/reads for the model to track.
    for (int i = 0; i < 12; i++) begin
      wr1_en = 1'b1; wr1_addr = AW'((i * 5) % 64); wr1_data = DW'(16'h1000 + i * 16'h0111);
      wr2_en = (i % 3) != 0; wr2_addr = AW'(63 - i * 3); wr2_data = DW'(16'hC000 + i);
      set_rd(AW'((i * 5) % 64), AW'(63 - i * 3), AW'(i == 0 ? 0 : ((i - 1) * 5) % 64));
      tick();
    end
    idle();

    // Soft clear while a write is in flight.
    wr1_en = 1'b1; wr1_addr = 6'd3; wr1_data = 16'h00FF;
    tick();
    idle();
    clear_req = 1'b1;
    wr2_en = 1'b1; wr2_addr = 6'd4; wr2_data = 16'h0F0F;
    set_rd(6'd4, 6'd3, 6'd4);
    settle();
    check("clear cycle bypass a", 64'(rd_data_w[0][15:0]), 64'h0F0F);
    check("clear cycle old b", 64'(rd_data_w[1][31:16]), 64'h00FF);
    tick();
    idle();
    count_clear("soft clear length", 1'b1);
    check("soft clear rd a", 64'(rd_data_w[0]), 64'h0);
    check("soft clear rd b", 64'(rd_data_w[1]), 64'h0);
    tick();

    // Writes to register 0 on both ports.
    wr1_en = 1'b1; wr1_addr = 6'd0; wr1_data = 16'hFFFF;
    wr2_en = 1'b1; wr2_addr = 6'd0; wr2_data = 16'h1234;
    set_rd(6'd0, 6'd0, 6'd0);
    settle();
    check("r0 bypass c", 64'(rd_data_w[2]), 64'h0);
    check("r0 bypass a", 64'(rd_data_w[0][15:0]), 64'h1234);
    tick();
    idle();
    settle();
    check("r0 no coll c", 64'(coll_w[2]), 64'h0);
    check("r0 coll a", 64'(coll_w[0]), 64'h1);
    check("r0 rd c", 64'(rd_data_w[2]), 64'h0);
    check("r0 rd b", 64'(rd_data_w[1][15:0]), 64'h1234);
    tick();

    // Reset mid-clear at counter 30 restarts the full sequence.
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_clear("reset mid-clear length", 1'b0);
    check("mid-clear rd b", 64'(rd_data_w[1]), 64'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
